// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset sequencer: state encoding and counter/index widths.
package rst_seq_pkg;

   localparam int CNT_W = 8;
   localparam int IDX_W = 3;

   localparam logic [2:0] ST_ASSERT   = 3'd0;
   localparam logic [2:0] ST_DELAY    = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK = 3'd2;
   localparam logic [2:0] ST_DONE     = 3'd3;
   localparam logic [2:0] ST_FAULT    = 3'd4;

endpackage

// File: rtl/rst_seq.sv
// Multi-stage reset sequencer: releases NUM_STAGES reset outputs in order,
// waiting for each stage's ack, with software restart and ack timeout.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int MIN_ASSERT  = 16,
   parameter int STAGE_DLY   = 10,
   parameter int ACK_TIMEOUT = 200
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  seq_done,
   output logic                  timeout_err,
   output logic [IDX_W-1:0]      err_stage
);

   localparam logic [CNT_W-1:0]      MIN_LAST = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0]      DLY_LAST = CNT_W'((STAGE_DLY == 0) ? 0 : STAGE_DLY - 1);
   localparam logic [CNT_W-1:0]      ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ONE      = NUM_STAGES'(1);

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
   logic                  seq_done_q, seq_done_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [IDX_W-1:0]      err_stage_q, err_stage_d;

   logic [NUM_STAGES-1:0] idx_mask;
   logic                  ack_cur;

   // One-hot select of the stage currently being sequenced.
   assign idx_mask = ONE << idx_q;
   assign ack_cur  = |(stage_ack & idx_mask);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      stage_rst_d   = stage_rst_q;
      seq_done_d    = seq_done_q;
      timeout_err_d = timeout_err_q;
      err_stage_d   = err_stage_q;

      if (sw_rst_req) begin
         state_d     = ST_ASSERT;
         cnt_d       = '0;
         idx_d       = '0;
         stage_rst_d = '1;
         seq_done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               stage_rst_d = '1;
               if (cnt_q == MIN_LAST) begin
                  cnt_d = '0;
                  // With no inter-stage delay the first release happens straight from here.
                  if (STAGE_DLY == 0) begin
                     stage_rst_d = '1 & ~idx_mask;
                     state_d     = ST_WAIT_ACK;
                  end else begin
                     state_d = ST_DELAY;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DELAY: begin
               if (cnt_q == DLY_LAST) begin
                  stage_rst_d = stage_rst_q & ~idx_mask;
                  cnt_d       = '0;
                  state_d     = ST_WAIT_ACK;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_ACK: begin
               // Ack takes priority over a timeout landing on the same cycle.
               if (ack_cur) begin
                  cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d    = ST_DONE;
                     seq_done_d = 1'b1;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = ST_DELAY;
                  end
               end else if (cnt_q == ACK_LAST) begin
                  state_d       = ST_FAULT;
                  stage_rst_d   = stage_rst_q | idx_mask;
                  timeout_err_d = 1'b1;
                  err_stage_d   = idx_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               stage_rst_d = '0;
               seq_done_d  = 1'b1;
            end
            ST_FAULT: begin
               seq_done_d = 1'b0;
            end
            default: begin
               state_d     = ST_ASSERT;
               cnt_d       = '0;
               idx_d       = '0;
               stage_rst_d = '1;
               seq_done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_ASSERT;
         cnt_q         <= '0;
         idx_q         <= '0;
         stage_rst_q   <= '1;
         seq_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         err_stage_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stage_rst_q   <= stage_rst_d;
         seq_done_q    <= seq_done_d;
         timeout_err_q <= timeout_err_d;
         err_stage_q   <= err_stage_d;
      end
   end

   assign stage_rst   = stage_rst_q;
   assign seq_done    = seq_done_q;
   assign timeout_err = timeout_err_q;
   assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a default-parameter instance plus a fast
// instance (MIN_ASSERT=1, STAGE_DLY=0) checked against edge-timed expectations.
module tb_rst_seq;

   localparam int N = 4;

   typedef struct {
      bit          sel;
      int          at;
      string       tag;
      logic [3:0]  rst;
      logic        done;
      logic        terr;
      logic [2:0]  estg;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sw_rst_req = 1'b0;
   logic         sw_f = 1'b0;
   logic [N-1:0] ack_en = '1;
   logic [N-1:0] stage_ack, stage_rst, stage_ack_f, stage_rst_f;
   logic         seq_done, timeout_err, seq_done_f, timeout_err_f;
   logic [2:0]   err_stage, err_stage_f;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t sbq[$];
   exp_t e;

   assign stage_ack   = ~stage_rst & ack_en;
   assign stage_ack_f = '1;

   rst_seq dut (
      .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .stage_ack(stage_ack),
      .stage_rst(stage_rst), .seq_done(seq_done), .timeout_err(timeout_err),
      .err_stage(err_stage)
   );

   rst_seq #(.NUM_STAGES(4), .MIN_ASSERT(1), .STAGE_DLY(0), .ACK_TIMEOUT(200)) dut_f (
      .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_f), .stage_ack(stage_ack_f),
      .stage_rst(stage_rst_f), .seq_done(seq_done_f), .timeout_err(timeout_err_f),
      .err_stage(err_stage_f)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
   endtask

   task automatic push(input bit sel, input int at, input string tag, input logic [3:0] r,
                       input logic d, input logic t, input logic [2:0] es);
      exp_t x;
      int   i;
      x.sel = sel; x.at = at; x.tag = tag; x.rst = r; x.done = d; x.terr = t; x.estg = es;
      i = 0;
      while (i < sbq.size() && sbq[i].at <= at) i++;
      sbq.insert(i, x);
   endtask

   // Expected release edges for a full default-parameter sequence starting after edge b.
   task automatic push_seq(input int b, input logic t, input logic [2:0] es, input string p);
      push(0, b + 25, {p, ".pre0"}, 4'b1111, 1'b0, t, es);
      push(0, b + 26, {p, ".rel0"}, 4'b1110, 1'b0, t, es);
      push(0, b + 36, {p, ".pre1"}, 4'b1110, 1'b0, t, es);
      push(0, b + 37, {p, ".rel1"}, 4'b1100, 1'b0, t, es);
      push(0, b + 48, {p, ".rel2"}, 4'b1000, 1'b0, t, es);
      push(0, b + 59, {p, ".rel3"}, 4'b0000, 1'b0, t, es);
      push(0, b + 60, {p, ".done"}, 4'b0000, 1'b1, t, es);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
         e = sbq.pop_front();
         if (e.at != cyc) begin
            chk({e.tag, ".late"}, 32'(cyc), 32'(e.at));
         end else if (e.sel) begin
            chk({e.tag, ".rst"},  32'(stage_rst_f),   32'(e.rst));
            chk({e.tag, ".done"}, 32'(seq_done_f),    32'(e.done));
            chk({e.tag, ".terr"}, 32'(timeout_err_f), 32'(e.terr));
            chk({e.tag, ".estg"}, 32'(err_stage_f),   32'(e.estg));
         end else begin
            chk({e.tag, ".rst"},  32'(stage_rst),   32'(e.rst));
            chk({e.tag, ".done"}, 32'(seq_done),    32'(e.done));
            chk({e.tag, ".terr"}, 32'(timeout_err), 32'(e.terr));
            chk({e.tag, ".estg"}, 32'(err_stage),   32'(e.estg));
         end
      end
   end

   initial begin
      int b;
      int x;
      exp_t lo;

      // Reset state and first sequence with acks following releases.
      push(0, 2, "reset", 4'b1111, 1'b0, 1'b0, 3'd0);
      push(1, 2, "f.reset", 4'b1111, 1'b0, 1'b0, 3'd0);
      b = 2;
      push_seq(b, 1'b0, 3'd0, "s1");
      push(0, b + 65, "s1.ackdrop", 4'b0000, 1'b1, 1'b0, 3'd0);
      push(1, b + 1, "f.rel0", 4'b1110, 1'b0, 1'b0, 3'd0);
      push(1, b + 2, "f.ack0", 4'b1110, 1'b0, 1'b0, 3'd0);
      push(1, b + 3, "f.rel1", 4'b1100, 1'b0, 1'b0, 3'd0);
      push(1, b + 5, "f.rel2", 4'b1000, 1'b0, 1'b0, 3'd0);
      push(1, b + 7, "f.rel3", 4'b0000, 1'b0, 1'b0, 3'd0);
      push(1, b + 8, "f.done", 4'b0000, 1'b1, 1'b0, 3'd0);
      wait_to(2);
      rst_n = 1'b1;
      wait_to(b + 62);
      ack_en = '0;
      wait_to(b + 66);
      ack_en = '1;

      // Software restart, then abort mid-DELAY before stage 1 release.
      x = b + 68;
      wait_to(x);
      sw_rst_req = 1'b1;
      push(0, x + 1, "s4.sw", 4'b1111, 1'b0, 1'b0, 3'd0);
      wait_to(x + 1);
      sw_rst_req = 1'b0;
      b = x + 1;
      push(0, b + 26, "s4.rel0", 4'b1110, 1'b0, 1'b0, 3'd0);
      push(0, b + 30, "s4.mid", 4'b1110, 1'b0, 1'b0, 3'd0);
      wait_to(b + 30);
      sw_rst_req = 1'b1;
      push(0, b + 31, "s4.abort", 4'b1111, 1'b0, 1'b0, 3'd0);
      wait_to(b + 31);
      sw_rst_req = 1'b0;
      b = b + 31;
      push_seq(b, 1'b0, 3'd0, "s4");

      // Stage 2 never acks: timeout fault.
      x = b + 62;
      wait_to(x);
      ack_en = 4'b1011;
      sw_rst_req = 1'b1;
      push(0, x + 1, "s2.sw", 4'b1111, 1'b0, 1'b0, 3'd0);
      b = x + 1;
      push(0, b + 26,  "s2.rel0",  4'b1110, 1'b0, 1'b0, 3'd0);
      push(0, b + 48,  "s2.rel2",  4'b1000, 1'b0, 1'b0, 3'd0);
      push(0, b + 247, "s2.pre",   4'b1000, 1'b0, 1'b0, 3'd0);
      push(0, b + 248, "s2.fault", 4'b1100, 1'b0, 1'b1, 3'd2);
      push(0, b + 255, "s2.hold",  4'b1100, 1'b0, 1'b1, 3'd2);
      wait_to(x + 1);
      sw_rst_req = 1'b0;

      // Recover with a software restart; fault record is sticky.
      x = b + 256;
      wait_to(x);
      ack_en = '1;
      sw_rst_req = 1'b1;
      push(0, x + 1, "s3.sw", 4'b1111, 1'b0, 1'b1, 3'd2);
      wait_to(x + 1);
      sw_rst_req = 1'b0;
      b = x + 1;
      push_seq(b, 1'b1, 3'd2, "s3");

      // Hard reset during DONE clears everything including the fault record.
      wait_to(b + 62);
      rst_n = 1'b0;
      push(0, b + 63, "s6.rst", 4'b1111, 1'b0, 1'b0, 3'd0);
      push(0, b + 64, "s6.hold", 4'b1111, 1'b0, 1'b0, 3'd0);
      wait_to(b + 63);
      rst_n = 1'b1;
      wait_to(b + 70);

      while (sbq.size() > 0) begin
         lo = sbq.pop_front();
         chk({lo.tag, ".unreached"}, 32'(cyc), 32'(lo.at));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
